// File: rtl/elelock_param_pkg.sv
// Shared types and constants for the electronic lock: FSM states, digit width
// and the seven-segment lookup ({g,f,e,d,c,b,a}, active-high).
package elelock_param_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_OPEN    = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_LOCKOUT = 2'd2
   } state_t;

   // Entry 9 first: packed index k gives the pattern for decimal k.
   localparam logic [9:0][6:0] SEG_TAB = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/elelock_param_if.sv
// Keypad inputs and display/status outputs of the lock, bundled as one port.
interface elelock_param_if #(parameter int DIGITS = 4);
   logic [9:0]          push;
   logic                mem;
   logic                cls;
   logic [7*DIGITS-1:0] led;
   logic [DIGITS-1:0]   dispen;
   logic                unlocked;
   logic                alarm;

   modport master (output push, mem, cls, input led, dispen, unlocked, alarm);
   modport slave  (input push, mem, cls, output led, dispen, unlocked, alarm);
endinterface

// File: rtl/elelock_param_seg7_decode.sv
// One display digit: decimal value to segments, blanked when not enabled.
module seg7_decode
   import elelock_param_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               en,
   output logic [6:0]         seg
);
   always_comb begin
      seg = 7'b0000000;
      if (en && digit <= DIGIT_W'(9)) seg = SEG_TAB[digit];
   end
endmodule

// File: rtl/elelock_param.sv
// Code lock: synchronised keypad, DIGITS-long entry buffer, OPEN/LOCKED/LOCKOUT
// FSM with saturating fail and lockout counters, seven-segment display.
module elelock_param
   import elelock_param_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 1000
) (
   input logic            CLK,
   input logic            RST,
   elelock_param_if.slave bus
);
   localparam int CW  = $clog2(DIGITS + 1);
   localparam int LKW = $clog2(LOCKOUT_CYC);
   localparam logic [LKW-1:0] LK_LAST = LKW'(LOCKOUT_CYC - 1);

   logic [11:0] raw, s1, s2, s3, ev;
   logic [9:0]  push_ev;
   logic        mem_ev, cls_ev, dig_ok;
   logic [DIGIT_W-1:0] dig;

   logic [DIGITS-1:0][DIGIT_W-1:0] ebuf_q, code_q;
   logic [CW-1:0]  cnt_q;
   logic [3:0]     fail_q;
   logic [LKW-1:0] lk_q;
   state_t         state_q, state_nx;
   logic           full, match;
   logic           clr_buf, shift, store, fail_inc, fail_clr, lk_run;
   logic [7*DIGITS-1:0] led_w;
   logic [DIGITS-1:0]   en_w;

   // Two-flop synchroniser plus one edge flop; the event is s2 & ~s3.
   assign raw = {bus.cls, bus.mem, bus.push};
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign ev      = s2 & ~s3;
   assign push_ev = ev[9:0];
   assign mem_ev  = ev[10];
   assign cls_ev  = ev[11];
   assign dig_ok  = $onehot(push_ev);

   always_comb begin
      dig = '0;
      for (int k = 0; k < 10; k++)
         if (push_ev[k]) dig = DIGIT_W'(k);
   end

   assign full  = (cnt_q == CW'(DIGITS));
   assign match = (ebuf_q == code_q);

   // Priority inside OPEN/LOCKED: cls, then mem, then a lone digit.
   always_comb begin
      state_nx = state_q;
      clr_buf  = 1'b0;
      shift    = 1'b0;
      store    = 1'b0;
      fail_inc = 1'b0;
      fail_clr = 1'b0;
      lk_run   = 1'b0;
      case (state_q)
         ST_OPEN: begin
            if (cls_ev) clr_buf = 1'b1;
            else if (mem_ev) begin
               if (full) begin
                  store    = 1'b1;
                  clr_buf  = 1'b1;
                  state_nx = ST_LOCKED;
               end
            end else if (dig_ok && !full) shift = 1'b1;
         end
         ST_LOCKED: begin
            if (cls_ev) clr_buf = 1'b1;
            else if (mem_ev) begin
               if (full) begin
                  clr_buf = 1'b1;
                  if (match) begin
                     fail_clr = 1'b1;
                     state_nx = ST_OPEN;
                  end else begin
                     fail_inc = 1'b1;
                     if (5'(fail_q) + 5'd1 == 5'(MAX_FAIL)) state_nx = ST_LOCKOUT;
                  end
               end
            end else if (dig_ok && !full) shift = 1'b1;
         end
         ST_LOCKOUT: begin
            lk_run = 1'b1;
            if (lk_q == LK_LAST) begin
               state_nx = ST_LOCKED;
               fail_clr = 1'b1;
               clr_buf  = 1'b1;
            end
         end
         default: state_nx = ST_OPEN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_OPEN;
         ebuf_q  <= '0;
         code_q  <= '0;
         cnt_q   <= '0;
         fail_q  <= '0;
         lk_q    <= '0;
      end else begin
         state_q <= state_nx;
         if (clr_buf) begin
            ebuf_q <= '0;
            cnt_q  <= '0;
         end else if (shift) begin
            for (int i = DIGITS - 1; i > 0; i--) ebuf_q[i] <= ebuf_q[i-1];
            ebuf_q[0] <= dig;
            cnt_q     <= cnt_q + CW'(1);
         end
         if (store) code_q <= ebuf_q;
         if (fail_clr) fail_q <= '0;
         else if (fail_inc && fail_q != 4'hF) fail_q <= fail_q + 4'd1;
         // Counter stops at LK_LAST, where the FSM leaves lockout.
         if (lk_run && lk_q != LK_LAST) lk_q <= lk_q + LKW'(1);
         else lk_q <= '0;
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign en_w[i] = (cnt_q > CW'(i));
      seg7_decode u_seg (
         .digit (ebuf_q[i]),
         .en    (en_w[i]),
         .seg   (led_w[7*i +: 7])
      );
   end

   assign bus.led      = led_w;
   assign bus.dispen   = en_w;
   assign bus.unlocked = (state_q == ST_OPEN);
   assign bus.alarm    = (state_q == ST_LOCKOUT);
endmodule
